// File: rtl/instr_fetch19.sv
// Instruction fetch unit for a 19-bit CPU: one-outstanding-request fetch FSM feeding a prefetch FIFO.
// Optional macro IFETCH_DECRYPT_EN stores each fetched word XORed with an alternating-bit key.
module instr_fetch19 #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [18:0] RESET_PC   = 19'd0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [18:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [18:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [18:0] redirect_pc,
   output logic        instr_valid,
   output logic [18:0] instr,
   output logic [18:0] instr_pc,
   input  logic        instr_ready
);

   localparam int unsigned AW    = 19;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_fetch_pc;
   logic [AW-1:0]     r_mem_data [FIFO_DEPTH];
   logic [AW-1:0]     r_mem_pc   [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic [AW-1:0]     w_wdata;

`ifdef IFETCH_DECRYPT_EN
   assign w_wdata = imem_rdata ^ 19'b1010101010101010101;
`else
   assign w_wdata = imem_rdata;
`endif

   // Fetch FSM next-state; a redirect suppresses issue and any keep of a response.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!rst && !redirect_valid && (r_count < DEPTH_C)) begin
               w_issue     = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               w_state_nxt = imem_rvalid ? S_IDLE : S_DROP;
            end else if (imem_rvalid) begin
               w_push      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_DROP: begin
            // The in-flight response is stale either way; it retires the request.
            if (imem_rvalid) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_pop       = instr_valid && instr_ready && !redirect_valid;
   assign imem_req    = w_issue;
   assign imem_addr   = r_fetch_pc;
   assign instr_valid = (r_count != '0);
   assign instr       = r_mem_data[r_rd_ptr];
   assign instr_pc    = r_mem_pc[r_rd_ptr];

   // Control state, fetch PC and FIFO pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
               r_fetch_pc <= r_fetch_pc + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // FIFO storage; the fetch PC is stable while a request is outstanding.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem_data[r_wr_ptr] <= w_wdata;
         r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch19.sv
// Self-checking bench for instr_fetch19: directed scenarios plus randomized traffic
// against a transaction-level scoreboard (outstanding flag, expected FIFO contents).
`timescale 1ns/1ps
module tb_instr_fetch19;

   localparam int          DEPTH  = 4;
   localparam logic [18:0] RST_PC = 19'd0;
`ifdef IFETCH_DECRYPT_EN
   localparam logic [18:0] KEY = 19'h55555;
`else
   localparam logic [18:0] KEY = 19'h00000;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [18:0] imem_addr;
   logic        imem_rvalid;
   logic [18:0] imem_rdata;
   logic        redirect_valid;
   logic [18:0] redirect_pc;
   logic        instr_valid;
   logic [18:0] instr;
   logic [18:0] instr_pc;
   logic        instr_ready;

   instr_fetch19 #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [18:0] pc; logic [18:0] data; } ent_t;
   typedef struct packed { logic [31:0] due; logic [18:0] addr; } mreq_t;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // memory model
   mreq_t mq[$];
   int    mem_lat  = 1;   // 0 selects random 1..3
   bit    mem_zero = 1'b0;
   int    last_due = 0;

   // scoreboard
   ent_t        q[$];
   bit          m_pending = 1'b0;
   bit          m_killed  = 1'b0;
   logic [18:0] m_req_addr = '0;
   logic [18:0] m_next = RST_PC;

   // observations
   logic        s_req, s_valid;
   logic [18:0] s_addr, s_pc, s_instr;
   ent_t        pops[$];
   logic [18:0] reqs[$];

   function automatic logic [18:0] mem_data(input logic [18:0] a);
      return mem_zero ? 19'h0 : a + 19'h100;
   endfunction

   // One clock cycle: drive memory response, sample and score at negedge, advance.
   task automatic tick();
      bit   exp_req, m_valid, pop, push;
      int   lat;
      ent_t e;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (mq.size() > 0 && int'(mq[0].due) == cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_data(mq[0].addr);
         void'(mq.pop_front());
      end
      @(negedge clk);
      s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
      s_pc = instr_pc;  s_instr = instr;
      m_valid = (q.size() != 0);
      exp_req = !rst && !redirect_valid && !m_pending && (q.size() < DEPTH);
      n_cmp++;
      if (s_req !== exp_req) begin
         n_err++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, s_req, exp_req);
      end
      if (s_req === 1'b1 && exp_req) begin
         n_cmp++;
         if (s_addr !== m_next) begin
            n_err++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, s_addr, m_next);
         end
      end
      n_cmp++;
      if (s_valid !== m_valid) begin
         n_err++; $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, s_valid, m_valid);
      end
      if (m_valid && s_valid === 1'b1) begin
         n_cmp++;
         if (s_pc !== q[0].pc || s_instr !== q[0].data) begin
            n_err++;
            $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                     cyc, s_pc, s_instr, q[0].pc, q[0].data);
         end
      end
      if (s_req === 1'b1) begin
         lat = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
         last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
         mq.push_back('{due: 32'(last_due), addr: s_addr});
         reqs.push_back(s_addr);
      end
      // advance the scoreboard across this clock edge
      if (rst) begin
         q.delete(); m_pending = 1'b0; m_killed = 1'b0; m_next = RST_PC;
      end else begin
         pop  = m_valid && instr_ready && !redirect_valid;
         push = m_pending && imem_rvalid && !m_killed && !redirect_valid;
         if (pop) pops.push_back('{pc: s_pc, data: s_instr});
         if (redirect_valid) begin
            q.delete();
            m_next = redirect_pc;
            if (m_pending && !imem_rvalid) m_killed = 1'b1;
         end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
               e.pc = m_req_addr; e.data = imem_rdata ^ KEY;
               q.push_back(e);
               m_next = m_req_addr + 19'd1;
            end
         end
         if (m_pending && imem_rvalid) begin m_pending = 1'b0; m_killed = 1'b0; end
         if (exp_req) begin m_pending = 1'b1; m_req_addr = m_next; end
      end
      @(posedge clk); #1;
      cyc++;
      redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      for (int g = 0; g < 10 && mq.size() != 0; g++) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_cmp++;
      if (s_req !== 1'b0 || s_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_outputs got req=%b valid=%b exp req=0 valid=0", s_req, s_valid);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== RST_PC) begin
         n_err++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h", s_req, s_addr, RST_PC);
      end
   endtask

   task automatic test_stream();
      mem_lat = 1; instr_ready = 1'b1;
      do_reset();
      pops.delete();
      for (int g = 0; g < 40 && pops.size() < 3; g++) tick();
      n_cmp++;
      if (pops.size() < 3) begin
         n_err++; $display("FAIL stream_count got=%0d exp=3", pops.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (pops[i].pc !== 19'(i) || pops[i].data !== ((19'h100 + 19'(i)) ^ KEY)) begin
               n_err++;
               $display("FAIL stream_%0d got pc=%h instr=%h exp pc=%h instr=%h", i,
                        pops[i].pc, pops[i].data, 19'(i), (19'h100 + 19'(i)) ^ KEY);
            end
         end
      end
   endtask

   task automatic test_fill();
      mem_lat = 0; instr_ready = 1'b0;
      do_reset();
      reqs.delete();
      for (int g = 0; g < 30; g++) tick();
      n_cmp++;
      if (reqs.size() != DEPTH) begin
         n_err++; $display("FAIL fill_req_count got=%0d exp=%0d", reqs.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (reqs[i] !== 19'(i)) begin
               n_err++; $display("FAIL fill_addr_%0d got=%h exp=%h", i, reqs[i], 19'(i));
            end
         end
      end
      n_cmp++;
      if (s_valid !== 1'b1 || s_pc !== 19'd0 || s_req !== 1'b0) begin
         n_err++; $display("FAIL fill_head got valid=%b pc=%h req=%b exp valid=1 pc=0 req=0",
                           s_valid, s_pc, s_req);
      end
      instr_ready = 1'b1;
   endtask

   task automatic test_redirect_wait();
      bit found = 1'b0;
      mem_lat = 3; instr_ready = 1'b1;
      do_reset();
      for (int g = 0; g < 60 && !found; g++) begin
         tick();
         if (s_req === 1'b1 && s_addr === 19'd5) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_err++; $display("FAIL redir_find_addr5 got=none exp=req_to_5");
      end
      redirect_valid = 1'b1; redirect_pc = 19'h00040;
      tick();
      reqs.delete(); pops.delete();
      for (int g = 0; g < 40 && pops.size() < 1; g++) tick();
      n_cmp++;
      if (reqs.size() == 0 || reqs[0] !== 19'h00040) begin
         n_err++; $display("FAIL redir_next_addr got=%h exp=00040", reqs.size() ? reqs[0] : 19'h7FFFF);
      end
      n_cmp++;
      if (pops.size() == 0 || pops[0].pc !== 19'h00040) begin
         n_err++; $display("FAIL redir_first_pc got=%h exp=00040", pops.size() ? pops[0].pc : 19'h7FFFF);
      end
   endtask

   task automatic test_wrap();
      logic [18:0] exp_pc;
      mem_lat = 1; instr_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 19'h7FFFE;
      tick();
      pops.delete();
      for (int g = 0; g < 40 && pops.size() < 3; g++) tick();
      exp_pc = 19'h7FFFE;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (i >= pops.size() || pops[i].pc !== exp_pc || pops[i].data !== ((exp_pc + 19'h100) ^ KEY)) begin
            n_err++; $display("FAIL wrap_%0d got pc=%h exp pc=%h", i,
                              (i < pops.size()) ? pops[i].pc : 19'h0BAD, exp_pc);
         end
         exp_pc = exp_pc + 19'd1;
      end
   endtask

   task automatic test_decrypt();
      mem_zero = 1'b1; mem_lat = 1; instr_ready = 1'b1;
      do_reset();
      pops.delete();
      for (int g = 0; g < 20 && pops.size() < 1; g++) tick();
      n_cmp++;
      if (pops.size() == 0 || pops[0].data !== KEY) begin
         n_err++; $display("FAIL decrypt got=%h exp=%h", pops.size() ? pops[0].data : 19'h7FFFF, KEY);
      end
      do_reset();
      mem_zero = 1'b0;
   endtask

   task automatic test_reset_wait();
      mem_lat = 2; instr_ready = 1'b1;
      do_reset();
      tick();
      n_cmp++;
      if (s_req !== 1'b1) begin
         n_err++; $display("FAIL rstwait_issue got=%b exp=1", s_req);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      n_cmp++;
      if (s_req !== 1'b1 || s_addr !== RST_PC) begin
         n_err++; $display("FAIL rstwait_next_addr got req=%b addr=%h exp req=1 addr=%h", s_req, s_addr, RST_PC);
      end
      tick();
      n_cmp++;
      if (s_valid !== 1'b0) begin
         n_err++; $display("FAIL rstwait_stale_push got valid=%b exp=0", s_valid);
      end
      for (int g = 0; g < 6; g++) tick();
   endtask

   task automatic test_random();
      mem_lat = 0;
      for (int i = 0; i < 1500; i++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = ($urandom_range(0, 1) == 0) ? 19'($urandom) : 19'h7FFFD + 19'($urandom_range(0, 3));
         end
         rst = (mq.size() == 0 && $urandom_range(0, 63) == 0);
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_stream();
      test_fill();
      test_redirect_wait();
      test_wrap();
      test_decrypt();
      test_reset_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch19.md
INSTR_FETCH19 -- requirements
Module: instr_fetch19

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, prefetch FIFO entries (power of two, 2..16).
REQ-002 Parameter: RESET_PC, 19'd0, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  single-cycle request pulse to instruction memory.
REQ-006 imem_addr  output  19  fetch address, valid while imem_req=1.
REQ-007 imem_rvalid  input  1  response strobe, one cycle, at least 1 cycle after imem_req.
REQ-008 imem_rdata  input  19  instruction word, valid with imem_rvalid.
REQ-009 redirect_valid  input  1  one-cycle branch/jump/call/return redirect from the 19-bit CPU.
REQ-010 redirect_pc  input  19  new fetch address, valid with redirect_valid.
REQ-011 instr_valid  output  1  FIFO head holds a valid instruction.
REQ-012 instr  output  19  FIFO head instruction word (opcode in [18:14]).
REQ-013 instr_pc  output  19  address the head instruction was fetched from.
REQ-014 instr_ready  input  1  CPU consumes head when instr_valid and instr_ready are both 1.

Function
REQ-015 Fetch FSM states: IDLE (no request outstanding), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded).
REQ-016 At most one memory request is outstanding at any time.
REQ-017 IDLE issues imem_req=1 with imem_addr=fetch_pc when fifo_count < FIFO_DEPTH and redirect_valid=0, then moves to WAIT next cycle.
REQ-018 WAIT on imem_rvalid: push {imem_rdata, request address} into FIFO, fetch_pc <= fetch_pc+1, return to IDLE.
REQ-019 fetch_pc increments modulo 2^19; 19'h7FFFF wraps to 19'h00000.
REQ-020 No push ever overflows: a request is issued only when a free slot exists, and that slot stays reserved until the response arrives.
REQ-021 FIFO pops on instr_valid and instr_ready; a push and a pop in the same cycle leave fifo_count unchanged.
REQ-022 instr, instr_pc and instr_valid are driven combinationally from the FIFO head, with no added latency.
REQ-023 Minimum latency: request issued in cycle N; rvalid in N+1 gives instr_valid=1 in N+2.
REQ-024 redirect_valid=1 has priority over pop, push and request issue in the same cycle.
REQ-025 On redirect: FIFO flushed (count=0, instr_valid=0 next cycle), fetch_pc <= redirect_pc, and no imem_req is issued that cycle.
REQ-026 A redirect while in WAIT moves the FSM to DROP; if imem_rvalid occurs in the same cycle as the redirect, that response is discarded and the FSM goes to IDLE.
REQ-027 DROP discards the next imem_rvalid, then returns to IDLE.
REQ-028 A redirect while in DROP stays in DROP.
REQ-029 imem_rvalid in IDLE is ignored.
REQ-030 A redirect from IDLE leads to a request for redirect_pc in the following cycle.

Reset
REQ-031 On rst=1 at a clock edge, state is cleared to: FSM=IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req=0, instr_valid=0.
REQ-032 rst overrides redirect, push and pop; an outstanding response arriving after reset is ignored.
REQ-033 The first imem_req is issued in the first cycle with rst=0, with imem_addr=RESET_PC.

Configuration
REQ-034 Macro IFETCH_DECRYPT_EN.
  - Defined: each pushed word is stored as imem_rdata XOR 19'b1010101010101010101 (decrypted at fetch).
  - Undefined: imem_rdata is stored unchanged.
  - Timing and all other behaviour are identical in both builds.

Verification
REQ-035 Reset, then a memory returning addr+19'h100 with 1-cycle latency and instr_ready=1 -> instr/instr_pc sequence 0x100/0, 0x101/1, 0x102/2.
REQ-036 instr_ready=0, FIFO_DEPTH=4 -> exactly 4 requests (addr 0..3), imem_req stays 0 afterwards, instr_valid=1 with instr_pc=0.
REQ-037 Redirect to 19'h00040 while a request for address 5 is outstanding, response returned 2 cycles later -> response discarded, next imem_addr=0x40, first instr_pc after the redirect=0x40.
REQ-038 Redirect to 19'h7FFFE -> fetched instr_pc sequence 7FFFE, 7FFFF, 00000.
REQ-039 IFETCH_DECRYPT_EN defined, imem_rdata=19'h00000 -> instr=19'h55555; undefined -> instr=19'h00000.
REQ-040 rst asserted while in WAIT with a late rvalid -> the late response is not pushed, and the next imem_addr is RESET_PC.
